// File: rtl/ram_rd_streamer.sv
// Purpose : read-side sequencer for the dual-clock block RAM; turns (addr, len) commands into a valid/ready word stream.
// Latency : command accepted at edge E0 -> first RAM read in cycle E0+1 -> first m_tvalid_o after edge E0+2.
// Backpressure: reads are issued only when a buffer slot is guaranteed; m_tready_i low stalls the stream with stable data.
//
// Ports:
//   clk_i, arstn_i            RAM read clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake; cmd_addr_i = first word, cmd_len_i = word count (0..MEM_DEPTH)
//   ram_rd_en_o/ram_rd_addr_o read request to the RAM; ram_rd_data_i returns one cycle after ram_rd_en_o
//   m_tdata_o/m_tvalid_o/m_tready_i/m_tlast_o   output stream, m_tlast_o marks a command's final word
//   busy_o                    reading, read in flight, or buffered words still waiting
//   abort_i                   (only with RAM_RD_STREAMER_ABORT_EN) drops the current command and all pending words
//
// Build option: define RAM_RD_STREAMER_ABORT_EN to add the abort_i input.

module ram_rd_streamer #(
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    input  logic [MEM_WIDTH-1:0]  ram_rd_data_i,
    output logic [MEM_WIDTH-1:0]  m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tlast_o,
    output logic                  busy_o
`ifdef RAM_RD_STREAMER_ABORT_EN
    ,
    input  logic                  abort_i
`endif
);

    localparam int PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W   = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W   = OCC_W + 1;
    localparam int ENTRY_W = MEM_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Abort source: tied off when the option is not built in.
    // ------------------------------------------------------------------
    logic abort;
`ifdef RAM_RD_STREAMER_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic                  in_read;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  in_flight_q, in_flight_d;
    logic                  in_flight_last_q, in_flight_last_d;

    logic [ENTRY_W-1:0]    buf_q [BUF_DEPTH];
    logic [ENTRY_W-1:0]    buf_d [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;

    logic                  cmd_fire;
    logic                  cmd_start;
    logic                  rd_last;
    logic                  pop;
    logic                  push;
    logic [SUM_W-1:0]      slots_used;
    logic [ENTRY_W-1:0]    head;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cmd_start)              state_d = ST_READ;
                ST_READ: if (ram_rd_en_o && rd_last) state_d = ST_IDLE;
                default:                             state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready_o = 1'b0;
        in_read     = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready_o = 1'b1;
            ST_READ: in_read     = 1'b1;
            default: cmd_ready_o = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Command handshake and read issue
    // ------------------------------------------------------------------
    assign cmd_fire  = cmd_valid_i && cmd_ready_o;
    // A zero-length command is consumed without leaving IDLE.
    assign cmd_start = cmd_fire && (cmd_len_i != '0);
    assign rd_last   = (remaining_q == LEN_WIDTH'(1));

    assign pop  = m_tvalid_o && m_tready_i;
    // The word of a read issued at an aborting edge is still returned by the
    // RAM one cycle later; in_flight_q is cleared so it is never captured.
    assign push = in_flight_q && !abort;

    // Slots that will be taken after this edge if no new read is issued:
    // buffered words plus the word still coming from the RAM, minus the one
    // leaving now. pop implies occ_q >= 1, so this never underflows.
    // The dependency on m_tready_i makes ram_rd_en_o combinational on it.
    assign slots_used = SUM_W'(occ_q) + SUM_W'(in_flight_q) - SUM_W'(pop);

    always_comb begin
        ram_rd_en_o   = in_read && (slots_used < SUM_W'(BUF_DEPTH));
        ram_rd_addr_o = addr_q;
    end

    always_comb begin
        addr_d           = addr_q;
        remaining_d      = remaining_q;
        in_flight_d      = ram_rd_en_o && !abort;
        in_flight_last_d = ram_rd_en_o && rd_last;
        if (abort) begin
            remaining_d = '0;
        end else if (cmd_start) begin
            addr_d      = cmd_addr_i;
            remaining_d = cmd_len_i;
        end else if (ram_rd_en_o) begin
            // MEM_DEPTH need not be a power of two, so wrap explicitly.
            addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            addr_q           <= '0;
            remaining_q      <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
        end else begin
            addr_q           <= addr_d;
            remaining_q      <= remaining_d;
            in_flight_q      <= in_flight_d;
            in_flight_last_q <= in_flight_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: circular FIFO of {last, data}
    // ------------------------------------------------------------------
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                buf_d[wr_ptr_q] = {in_flight_last_q, ram_rd_data_i};
                wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // ------------------------------------------------------------------
    // Stream outputs; data and last read as zero whenever nothing is valid.
    // ------------------------------------------------------------------
    assign head = buf_q[rd_ptr_q];

    always_comb begin
        m_tvalid_o = (occ_q != '0);
        m_tdata_o  = m_tvalid_o ? head[MEM_WIDTH-1:0] : '0;
        m_tlast_o  = m_tvalid_o && head[MEM_WIDTH];
        busy_o     = in_read || in_flight_q || m_tvalid_o;
    end

endmodule

// File: tb/tb_ram_rd_streamer.sv
module tb_ram_rd_streamer;

    localparam int MW = 16;
    localparam int MD = 64;
    localparam int AW = 6;
    localparam int LW = 7;
    localparam int BD = 2;

    logic          clk_i = 1'b0;
    logic          arstn_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i;
    logic [LW-1:0] cmd_len_i;
    logic          ram_rd_en_o;
    logic [AW-1:0] ram_rd_addr_o;
    logic [MW-1:0] ram_rd_data_i = '0;
    logic [MW-1:0] m_tdata_o;
    logic          m_tvalid_o;
    logic          m_tready_i = 1'b1;
    logic          m_tlast_o;
    logic          busy_o;
    logic          abort_tb = 1'b0;

    always #5 clk_i = ~clk_i;

    ram_rd_streamer #(
        .MEM_WIDTH (MW),
        .MEM_DEPTH (MD),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .BUF_DEPTH (BD)
    ) dut (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_len_i    (cmd_len_i),
        .ram_rd_en_o  (ram_rd_en_o),
        .ram_rd_addr_o(ram_rd_addr_o),
        .ram_rd_data_i(ram_rd_data_i),
        .m_tdata_o    (m_tdata_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tready_i   (m_tready_i),
        .m_tlast_o    (m_tlast_o),
        .busy_o       (busy_o)
`ifdef RAM_RD_STREAMER_ABORT_EN
        ,
        .abort_i      (abort_tb)
`endif
    );

    // Registered-read RAM model.
    logic [MW-1:0] mem [MD];
    always @(posedge clk_i) begin
        if (ram_rd_en_o) ram_rd_data_i <= mem[ram_rd_addr_o];
    end

    // Scoreboard state
    logic [MW:0]   exp_q [$];
    logic [AW-1:0] exp_addr_q [$];
    int n_vec = 0;
    int n_err = 0;
    int n_beats = 0;
    int n_last = 0;
    int tr_mode = 0;  // 0: ready always, 1: random 50%, 2: never ready

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Downstream ready driver
    always @(posedge clk_i) begin
        #1;
        case (tr_mode)
            0:       m_tready_i = 1'b1;
            1:       m_tready_i = 1'($urandom_range(0, 1));
            default: m_tready_i = 1'b0;
        endcase
    end

    // Monitor: compares every beat and every RAM read against the queues.
    logic        prev_stall = 1'b0;
    logic [MW:0] prev_beat = '0;
    logic        abort_prev = 1'b0;
    always @(negedge clk_i) begin
        if (!arstn_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !abort_prev) begin
                check("stall_valid_held", 32'(m_tvalid_o), 32'd1);
                check("stall_data_held", 32'({m_tlast_o, m_tdata_o}), 32'(prev_beat));
            end
            if (m_tvalid_o && m_tready_i) begin
                n_beats++;
                if (m_tlast_o) n_last++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got 0x%0h, required no beat", {m_tlast_o, m_tdata_o});
                end else begin
                    check("beat_last_data", 32'({m_tlast_o, m_tdata_o}), 32'(exp_q.pop_front()));
                end
            end
            if (ram_rd_en_o) begin
                if (exp_addr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_read: got addr %0d, required no read", ram_rd_addr_o);
                end else begin
                    check("rd_addr", 32'(ram_rd_addr_o), 32'(exp_addr_q.pop_front()));
                end
            end
            prev_stall = m_tvalid_o && !m_tready_i;
            prev_beat  = {m_tlast_o, m_tdata_o};
        end
        abort_prev = abort_tb;
    end

    // Issue one command; on handshake, push the reference words and addresses.
    task automatic send_cmd(input int a, input int l);
        int  waitc = 0;
        bit  done = 0;
        cmd_addr_i  = AW'(a);
        cmd_len_i   = LW'(l);
        cmd_valid_i = 1'b1;
        while (!done) begin
            @(negedge clk_i);
            if (cmd_ready_o) begin
                @(posedge clk_i);
                for (int i = 0; i < l; i++) begin
                    int   idx = (a + i) % MD;
                    logic lst = (i == l - 1);
                    exp_q.push_back({lst, mem[idx]});
                    exp_addr_q.push_back(AW'(idx));
                end
                done = 1;
            end else if (++waitc > 500) begin
                n_vec++;
                n_err++;
                $display("FAIL cmd_accept_timeout: got cmd_ready_o=0 for %0d cycles, required 1", waitc);
                done = 1;
            end
        end
        #1 cmd_valid_i = 1'b0;
    endtask

    // Wait until the scoreboard is empty and the DUT idle, bounded.
    task automatic wait_idle();
        int c = 0;
        while ((exp_q.size() != 0 || busy_o) && c < 2000) begin
            @(negedge clk_i);
            c++;
        end
        check("drain_within_budget", 32'(c < 2000), 32'd1);
        check("reads_all_issued", 32'(exp_addr_q.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int run;
        int l0;
        int b0;
        arstn_i     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_len_i   = '0;
        for (int i = 0; i < MD; i++) mem[i] = MW'(i + 16'h100);

        // 1: reset values
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_rd_en", 32'(ram_rd_en_o), 32'd0);
        check("rst_rd_addr", 32'(ram_rd_addr_o), 32'd0);
        check("rst_tvalid", 32'(m_tvalid_o), 32'd0);
        check("rst_tdata", 32'(m_tdata_o), 32'd0);
        check("rst_tlast", 32'(m_tlast_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        arstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("post_rst_tvalid", 32'(m_tvalid_o), 32'd0);

        // 2: basic read, latency and no gaps
        tr_mode = 0;
        l0 = n_last;
        send_cmd(5, 4);
        k = 0;
        @(negedge clk_i);
        while (!m_tvalid_o && k < 10) begin
            k++;
            @(negedge clk_i);
        end
        check("first_valid_latency", 32'(k), 32'd2);
        run = 0;
        while (m_tvalid_o && run < 10) begin
            run++;
            @(negedge clk_i);
        end
        check("contiguous_beats", 32'(run), 32'd4);
        wait_idle();
        check("basic_tlast_count", 32'(n_last - l0), 32'd1);

        // 3: address wrap
        send_cmd(62, 4);
        wait_idle();

        // 4: back-pressure
        tr_mode = 1;
        send_cmd(int'($urandom_range(0, MD - 1)), 8);
        wait_idle();
        tr_mode = 0;

        // 5: zero length, full length, back-to-back
        send_cmd(10, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("len0_cmd_ready", 32'(cmd_ready_o), 32'd1);
        end
        wait_idle();
        l0 = n_last;
        b0 = n_beats;
        send_cmd(int'($urandom_range(0, MD - 1)), MD);
        wait_idle();
        check("full_len_beats", 32'(n_beats - b0), 32'(MD));
        check("full_len_tlasts", 32'(n_last - l0), 32'd1);
        l0 = n_last;
        b0 = n_beats;
        send_cmd(20, 3);
        send_cmd(40, 2);
        wait_idle();
        check("b2b_beats", 32'(n_beats - b0), 32'd5);
        check("b2b_tlasts", 32'(n_last - l0), 32'd2);

        // Randomized commands with random RAM contents and ready pattern
        for (int it = 0; it < 20; it++) begin
            int ncmd;
            for (int i = 0; i < MD; i++) mem[i] = MW'($urandom);
            tr_mode = int'($urandom_range(0, 1));
            ncmd = int'($urandom_range(1, 3));
            for (int c = 0; c < ncmd; c++) begin
                int len;
                len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MD)) : int'($urandom_range(0, 12));
                send_cmd(int'($urandom_range(0, MD - 1)), len);
            end
            wait_idle();
        end
        tr_mode = 0;
        for (int i = 0; i < MD; i++) mem[i] = MW'(i + 16'h100);

        // 6a: reset mid-command
        tr_mode = 1;
        send_cmd(7, 20);
        repeat (6) @(posedge clk_i);
        #1;
        arstn_i = 1'b0;
        #1;
        check("midrst_tvalid", 32'(m_tvalid_o), 32'd0);
        check("midrst_rd_en", 32'(ram_rd_en_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
        tr_mode = 0;
        send_cmd(30, 5);
        wait_idle();

`ifdef RAM_RD_STREAMER_ABORT_EN
        // 6b: abort with a stalled stream
        tr_mode = 2;
        send_cmd(11, 8);
        repeat (5) @(posedge clk_i);
        #1;
        abort_tb = 1'b1;
        @(posedge clk_i);
        #1;
        abort_tb = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk_i);
        check("abort_tvalid", 32'(m_tvalid_o), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("abort_rd_en", 32'(ram_rd_en_o), 32'd0);
        @(posedge clk_i);
        #1;
        tr_mode = 0;
        send_cmd(50, 3);
        wait_idle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
